ctrl_decode_stage: RTL and testbench

Registered instruction-decode control stage with built-in bubble, flush and multi-cycle-multiply sequencing. It sits at the ID/EX boundary of the MIPS pipeline. Each cycle it decodes the 6-bit opcode into the control bundle and registers it for EX. It also inserts bubbles on hazards and flushes, and holds a MUL in EX for `MUL_CYCLES` while stalling the front end. Illegal opcodes are flagged and counted.

---
 rtl/ctrl_pkg.sv | 57 +++++
 rtl/ctrl_decode_lut.sv | 74 +++++++
 rtl/ctrl_decode_stage.sv | 119 +++++++++++
 tb/tb_ctrl_decode_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-command and branch-condition encodings for the ID/EX decode stage,
// plus the FSM state type and the packed control bundle carried into EX.
package ctrl_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_MUL  = 6'b000010;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_OR   = 6'b000110;
  localparam logic [5:0] OP_NOR  = 6'b000111;
  localparam logic [5:0] OP_XOR  = 6'b001000;
  localparam logic [5:0] OP_SLA  = 6'b001001;
  localparam logic [5:0] OP_SLL  = 6'b001010;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_SRL  = 6'b001100;
  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_SUBI = 6'b100001;
  localparam logic [5:0] OP_LD   = 6'b100100;
  localparam logic [5:0] OP_ST   = 6'b100101;
  localparam logic [5:0] OP_BEZ  = 6'b101000;
  localparam logic [5:0] OP_BNE  = 6'b101001;
  localparam logic [5:0] OP_JMP  = 6'b101010;

  localparam logic [3:0] EXE_ADD          = 4'b0000;
  localparam logic [3:0] EXE_SUB          = 4'b0010;
  localparam logic [3:0] EXE_AND          = 4'b0100;
  localparam logic [3:0] EXE_OR           = 4'b0101;
  localparam logic [3:0] EXE_NOR          = 4'b0110;
  localparam logic [3:0] EXE_XOR          = 4'b0111;
  localparam logic [3:0] EXE_SHIFT_LEFT   = 4'b1000;
  localparam logic [3:0] EXE_SHIFT_ART    = 4'b1001;
  localparam logic [3:0] EXE_SHIFT_LOG    = 4'b1010;
  localparam logic [3:0] EXE_MUL          = 4'b1011;
  localparam logic [3:0] EXE_NO_OPERATION = 4'b1111;

  localparam logic [1:0] COND_BEZ  = 2'b01;
  localparam logic [1:0] COND_BNE  = 2'b10;
  localparam logic [1:0] COND_JUMP = 2'b11;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       branch_en;
    logic       is_imm;
    logic       st_or_bne;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic [3:0] exe_cmd;
    logic [1:0] branch_cmd;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode_lut.sv
// Purely combinational opcode decoder: control bundle, legality, and whether the
// opcode is a live instruction (NOP is legal but produces a bubble).
module ctrl_decode_lut
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  output ctrl_bundle_t bundle_o,
  output logic         legal_o,
  output logic         live_o
);

  always_comb begin
    bundle_o = '0;
    legal_o  = 1'b1;
    live_o   = 1'b1;
    unique case (opcode_i)
      OP_NOP:  live_o = 1'b0;
      OP_ADD:  begin bundle_o.exe_cmd = EXE_ADD;        bundle_o.wb_en = 1'b1; end
      OP_MUL:  begin bundle_o.exe_cmd = EXE_MUL;        bundle_o.wb_en = 1'b1; end
      OP_SUB:  begin bundle_o.exe_cmd = EXE_SUB;        bundle_o.wb_en = 1'b1; end
      OP_AND:  begin bundle_o.exe_cmd = EXE_AND;        bundle_o.wb_en = 1'b1; end
      OP_OR:   begin bundle_o.exe_cmd = EXE_OR;         bundle_o.wb_en = 1'b1; end
      OP_NOR:  begin bundle_o.exe_cmd = EXE_NOR;        bundle_o.wb_en = 1'b1; end
      OP_XOR:  begin bundle_o.exe_cmd = EXE_XOR;        bundle_o.wb_en = 1'b1; end
      OP_SLA:  begin bundle_o.exe_cmd = EXE_SHIFT_LEFT; bundle_o.wb_en = 1'b1; end
      OP_SLL:  begin bundle_o.exe_cmd = EXE_SHIFT_LEFT; bundle_o.wb_en = 1'b1; end
      OP_SRA:  begin bundle_o.exe_cmd = EXE_SHIFT_ART;  bundle_o.wb_en = 1'b1; end
      OP_SRL:  begin bundle_o.exe_cmd = EXE_SHIFT_LOG;  bundle_o.wb_en = 1'b1; end
      OP_ADDI: begin
        bundle_o.exe_cmd = EXE_ADD; bundle_o.wb_en = 1'b1; bundle_o.is_imm = 1'b1;
      end
      OP_SUBI: begin
        bundle_o.exe_cmd = EXE_SUB; bundle_o.wb_en = 1'b1; bundle_o.is_imm = 1'b1;
      end
      OP_LD: begin
        bundle_o.exe_cmd   = EXE_ADD;
        bundle_o.wb_en     = 1'b1;
        bundle_o.is_imm    = 1'b1;
        bundle_o.st_or_bne = 1'b1;
        bundle_o.mem_r_en  = 1'b1;
      end
      OP_ST: begin
        bundle_o.exe_cmd   = EXE_ADD;
        bundle_o.is_imm    = 1'b1;
        bundle_o.st_or_bne = 1'b1;
        bundle_o.mem_w_en  = 1'b1;
      end
      OP_BEZ: begin
        bundle_o.exe_cmd    = EXE_NO_OPERATION;
        bundle_o.is_imm     = 1'b1;
        bundle_o.branch_en  = 1'b1;
        bundle_o.branch_cmd = COND_BEZ;
      end
      OP_BNE: begin
        bundle_o.exe_cmd    = EXE_NO_OPERATION;
        bundle_o.is_imm     = 1'b1;
        bundle_o.branch_en  = 1'b1;
        bundle_o.branch_cmd = COND_BNE;
        bundle_o.st_or_bne  = 1'b1;
      end
      OP_JMP: begin
        bundle_o.exe_cmd    = EXE_NO_OPERATION;
        bundle_o.is_imm     = 1'b1;
        bundle_o.branch_en  = 1'b1;
        bundle_o.branch_cmd = COND_JUMP;
      end
      default: begin
        legal_o = 1'b0;
        live_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID/EX decode register with bubble/flush insertion, multi-cycle MUL hold with
// front-end stall, and a saturating illegal-opcode counter.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int EXE_CMD_W  = 4,
  parameter int MUL_CYCLES = 3,
  parameter int ILL_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [5:0]           opcode_i,
  input  logic                 hazard_detected,
  input  logic                 flush_i,
  output logic                 valid_o,
  output logic                 branch_en_o,
  output logic                 is_imm_o,
  output logic                 st_or_bne_o,
  output logic                 wb_en_o,
  output logic                 mem_r_en_o,
  output logic                 mem_w_en_o,
  output logic [EXE_CMD_W-1:0] exe_cmd_o,
  output logic [1:0]           branch_cmd_o,
  output logic                 stall_o,
  output logic                 illegal_o,
  output logic [ILL_CNT_W-1:0] illegal_cnt_o
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  ctrl_bundle_t         lut_p0;
  logic                 legal_p0;
  logic                 vld_p0;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  ctrl_bundle_t         ctrl_p1, ctrl_d;
  logic                 vld_p1, vld_d;
  logic                 ill_p1, ill_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  ctrl_decode_lut u_lut (
    .opcode_i (opcode_i),
    .bundle_o (lut_p0),
    .legal_o  (legal_p0),
    .live_o   (vld_p0)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_p1;
    vld_d     = vld_p1;
    ill_d     = 1'b0;
    ill_cnt_d = ill_cnt_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ctrl_d  = '0;
      vld_d   = 1'b0;
    end else if (state_q == ST_MUL_BUSY) begin
      // MUL held in EX; writeback only on the final occupancy cycle
      cnt_d        = cnt_q - CNT_W'(1);
      ctrl_d.wb_en = (cnt_q == CNT_W'(1));
      if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
    end else begin
      ctrl_d = '0;
      vld_d  = 1'b0;
      if (valid_i && !hazard_detected) begin
        if (!legal_p0) begin
          ill_d = 1'b1;
          if (ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
        end else begin
          ctrl_d = lut_p0;
          vld_d  = vld_p0;
          if (opcode_i == OP_MUL && MUL_CYCLES > 1) begin
            ctrl_d.wb_en = 1'b0;
            state_d      = ST_MUL_BUSY;
            cnt_d        = CNT_W'(MUL_CYCLES - 1);
          end
        end
      end
    end
  end

  // ---- ID/EX boundary (p0 -> p1) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ctrl_p1   <= '0;
      vld_p1    <= 1'b0;
      ill_p1    <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_p1   <= ctrl_d;
      vld_p1    <= vld_d;
      ill_p1    <= ill_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign valid_o       = vld_p1;
  assign branch_en_o   = ctrl_p1.branch_en;
  assign is_imm_o      = ctrl_p1.is_imm;
  assign st_or_bne_o   = ctrl_p1.st_or_bne;
  assign wb_en_o       = ctrl_p1.wb_en;
  assign mem_r_en_o    = ctrl_p1.mem_r_en;
  assign mem_w_en_o    = ctrl_p1.mem_w_en;
  assign exe_cmd_o     = EXE_CMD_W'(ctrl_p1.exe_cmd);
  assign branch_cmd_o  = ctrl_p1.branch_cmd;
  assign stall_o       = (state_q == ST_MUL_BUSY);
  assign illegal_o     = ill_p1;
  assign illegal_cnt_o = ill_cnt_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: two instances (MUL_CYCLES=3/ILL_CNT_W=8 and
// MUL_CYCLES=1/ILL_CNT_W=2/EXE_CMD_W=6) share stimulus and are checked against a table model.
module tb_ctrl_decode_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_i = 1'b0;
  logic [5:0] opcode_i = 6'd0;
  logic       hazard_detected = 1'b0;
  logic       flush_i = 1'b0;

  logic       a_valid, a_br, a_imm, a_sob, a_wb, a_mr, a_mw, a_stall, a_ill;
  logic [3:0] a_exe;
  logic [1:0] a_bcmd;
  logic [7:0] a_cnt;
  logic       b_valid, b_br, b_imm, b_sob, b_wb, b_mr, b_mw, b_stall, b_ill;
  logic [5:0] b_exe;
  logic [1:0] b_bcmd;
  logic [1:0] b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.EXE_CMD_W(4), .MUL_CYCLES(3), .ILL_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .valid_i(valid_i), .opcode_i(opcode_i),
    .hazard_detected(hazard_detected), .flush_i(flush_i),
    .valid_o(a_valid), .branch_en_o(a_br), .is_imm_o(a_imm), .st_or_bne_o(a_sob),
    .wb_en_o(a_wb), .mem_r_en_o(a_mr), .mem_w_en_o(a_mw), .exe_cmd_o(a_exe),
    .branch_cmd_o(a_bcmd), .stall_o(a_stall), .illegal_o(a_ill), .illegal_cnt_o(a_cnt)
  );

  ctrl_decode_stage #(.EXE_CMD_W(6), .MUL_CYCLES(1), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .valid_i(valid_i), .opcode_i(opcode_i),
    .hazard_detected(hazard_detected), .flush_i(flush_i),
    .valid_o(b_valid), .branch_en_o(b_br), .is_imm_o(b_imm), .st_or_bne_o(b_sob),
    .wb_en_o(b_wb), .mem_r_en_o(b_mr), .mem_w_en_o(b_mw), .exe_cmd_o(b_exe),
    .branch_cmd_o(b_bcmd), .stall_o(b_stall), .illegal_o(b_ill), .illegal_cnt_o(b_cnt)
  );

  // Expected visible state per instance; hold = MUL cycles still to be shown after this one
  typedef struct {
    bit valid, br, imm, sob, wb, mr, mw, ill;
    int exe, bcmd, cnt, hold;
  } exp_t;

  exp_t e[2];
  int   mul_cycles[2] = '{3, 1};
  int   cnt_max[2]    = '{255, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_decode(input logic [5:0] op, output bit legal, output exp_t d);
    d = '{default: 0};
    legal = 1'b1;
    case (op)
      6'b000000: ;
      6'b000001: begin d.valid = 1; d.wb = 1; d.exe = 0;  end
      6'b000010: begin d.valid = 1; d.wb = 1; d.exe = 11; end
      6'b000011: begin d.valid = 1; d.wb = 1; d.exe = 2;  end
      6'b000101: begin d.valid = 1; d.wb = 1; d.exe = 4;  end
      6'b000110: begin d.valid = 1; d.wb = 1; d.exe = 5;  end
      6'b000111: begin d.valid = 1; d.wb = 1; d.exe = 6;  end
      6'b001000: begin d.valid = 1; d.wb = 1; d.exe = 7;  end
      6'b001001: begin d.valid = 1; d.wb = 1; d.exe = 8;  end
      6'b001010: begin d.valid = 1; d.wb = 1; d.exe = 8;  end
      6'b001011: begin d.valid = 1; d.wb = 1; d.exe = 9;  end
      6'b001100: begin d.valid = 1; d.wb = 1; d.exe = 10; end
      6'b100000: begin d.valid = 1; d.wb = 1; d.imm = 1; d.exe = 0; end
      6'b100001: begin d.valid = 1; d.wb = 1; d.imm = 1; d.exe = 2; end
      6'b100100: begin d.valid = 1; d.wb = 1; d.imm = 1; d.sob = 1; d.mr = 1; d.exe = 0; end
      6'b100101: begin d.valid = 1; d.imm = 1; d.sob = 1; d.mw = 1; d.exe = 0; end
      6'b101000: begin d.valid = 1; d.imm = 1; d.br = 1; d.bcmd = 1; d.exe = 15; end
      6'b101001: begin d.valid = 1; d.imm = 1; d.br = 1; d.bcmd = 2; d.sob = 1; d.exe = 15; end
      6'b101010: begin d.valid = 1; d.imm = 1; d.br = 1; d.bcmd = 3; d.exe = 15; end
      default:   legal = 1'b0;
    endcase
  endtask

  task automatic model_step(input int m);
    exp_t d;
    bit   legal;
    int   cnt;
    cnt = e[m].cnt;
    if (flush_i) begin
      e[m] = '{default: 0};
      e[m].cnt = cnt;
    end else if (e[m].hold > 0) begin
      e[m].hold = e[m].hold - 1;
      e[m].wb   = (e[m].hold == 0);
      e[m].ill  = 0;
    end else begin
      e[m] = '{default: 0};
      e[m].cnt = cnt;
      if (valid_i && !hazard_detected) begin
        ref_decode(opcode_i, legal, d);
        if (!legal) begin
          e[m].ill = 1;
          e[m].cnt = (cnt < cnt_max[m]) ? cnt + 1 : cnt;
        end else begin
          d.cnt = cnt;
          if (opcode_i == 6'b000010) begin
            d.hold = mul_cycles[m] - 1;
            d.wb   = (d.hold == 0);
          end
          e[m] = d;
        end
      end
    end
  endtask

  task automatic model_reset();
    e[0] = '{default: 0};
    e[1] = '{default: 0};
  endtask

  task automatic compare_all();
    chk("a.valid", 32'(a_valid), 32'(e[0].valid));
    chk("a.branch_en", 32'(a_br), 32'(e[0].br));
    chk("a.is_imm", 32'(a_imm), 32'(e[0].imm));
    chk("a.st_or_bne", 32'(a_sob), 32'(e[0].sob));
    chk("a.wb_en", 32'(a_wb), 32'(e[0].wb));
    chk("a.mem_r_en", 32'(a_mr), 32'(e[0].mr));
    chk("a.mem_w_en", 32'(a_mw), 32'(e[0].mw));
    chk("a.exe_cmd", 32'(a_exe), 32'(e[0].exe));
    chk("a.branch_cmd", 32'(a_bcmd), 32'(e[0].bcmd));
    chk("a.stall", 32'(a_stall), 32'(e[0].hold > 0));
    chk("a.illegal", 32'(a_ill), 32'(e[0].ill));
    chk("a.illegal_cnt", 32'(a_cnt), 32'(e[0].cnt));
    chk("b.valid", 32'(b_valid), 32'(e[1].valid));
    chk("b.branch_en", 32'(b_br), 32'(e[1].br));
    chk("b.is_imm", 32'(b_imm), 32'(e[1].imm));
    chk("b.st_or_bne", 32'(b_sob), 32'(e[1].sob));
    chk("b.wb_en", 32'(b_wb), 32'(e[1].wb));
    chk("b.mem_r_en", 32'(b_mr), 32'(e[1].mr));
    chk("b.mem_w_en", 32'(b_mw), 32'(e[1].mw));
    chk("b.exe_cmd", 32'(b_exe), 32'(e[1].exe));
    chk("b.branch_cmd", 32'(b_bcmd), 32'(e[1].bcmd));
    chk("b.stall", 32'(b_stall), 32'(e[1].hold > 0));
    chk("b.illegal", 32'(b_ill), 32'(e[1].ill));
    chk("b.illegal_cnt", 32'(b_cnt), 32'(e[1].cnt));
  endtask

  // One clock: inputs already applied; model advances on the edge, outputs sampled 1ns later
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [5:0] op, input bit hz, input bit fl);
    valid_i = v;
    opcode_i = op;
    hazard_detected = hz;
    flush_i = fl;
    cycle();
  endtask

  logic [5:0] legal_ops [19] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h05, 6'h06, 6'h07,
                                6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h20, 6'h21,
                                6'h24, 6'h25, 6'h28, 6'h29, 6'h2a};

  initial begin
    // Reset state
    model_reset();
    #1;
    compare_all();
    cycle();
    rst = 1'b0;

    // Basic decode: ADD, LD, ST, BNE
    drive(1, 6'b000001, 0, 0);
    drive(1, 6'b100100, 0, 0);
    drive(1, 6'b100101, 0, 0);
    drive(1, 6'b101001, 0, 0);
    chk("bne.branch_cmd", 32'(a_bcmd), 32'd2);
    chk("bne.st_or_bne", 32'(a_sob), 32'd1);
    chk("bne.exe_cmd", 32'(a_exe), 32'hf);
    chk("bne.exe_cmd_w6", 32'(b_exe), 32'hf);

    // Hazard bubble then reissue
    drive(1, 6'b100100, 0, 0);
    drive(1, 6'b000011, 1, 0);
    chk("hazard.valid", 32'(a_valid), 32'd0);
    chk("hazard.wb_en", 32'(a_wb), 32'd0);
    drive(1, 6'b000011, 0, 0);
    chk("reissue.exe_cmd", 32'(a_exe), 32'd2);

    // MUL sequencing; front end keeps presenting ADD while stalled
    drive(1, 6'b000010, 0, 0);
    chk("mul1.stall", 32'(a_stall), 32'd1);
    chk("mul1.wb_en", 32'(a_wb), 32'd0);
    chk("mul_single.stall", 32'(b_stall), 32'd0);
    chk("mul_single.wb_en", 32'(b_wb), 32'd1);
    drive(1, 6'b000001, 0, 0);
    drive(1, 6'b000001, 1, 0);
    chk("mul3.stall", 32'(a_stall), 32'd0);
    chk("mul3.wb_en", 32'(a_wb), 32'd1);
    chk("mul3.exe_cmd", 32'(a_exe), 32'hb);
    drive(1, 6'b000001, 0, 0);
    chk("after_mul.exe_cmd", 32'(a_exe), 32'd0);

    // Back-to-back MULs
    drive(1, 6'b000010, 0, 0);
    drive(1, 6'b000010, 0, 0);
    drive(1, 6'b000010, 0, 0);
    drive(1, 6'b000010, 0, 0);
    drive(0, 6'b000000, 0, 0);
    drive(0, 6'b000000, 0, 0);
    drive(0, 6'b000000, 0, 0);

    // Flush in MUL cycle 2
    drive(1, 6'b000010, 0, 0);
    drive(0, 6'b000000, 0, 0);
    drive(1, 6'b000001, 1, 1);
    chk("flush.stall", 32'(a_stall), 32'd0);
    chk("flush.valid", 32'(a_valid), 32'd0);
    drive(1, 6'b000001, 0, 0);

    // Illegal opcodes, saturation, hazard suppression
    drive(1, 6'h3f, 0, 0);
    drive(1, 6'h3f, 0, 0);
    drive(1, 6'h3f, 0, 0);
    chk("ill3.count", 32'(a_cnt), 32'd3);
    drive(1, 6'h3f, 0, 0);
    drive(1, 6'h3f, 0, 0);
    chk("ill5.count_sat", 32'(b_cnt), 32'd3);
    chk("ill5.count", 32'(a_cnt), 32'd5);
    drive(1, 6'h3f, 1, 0);
    chk("ill_hazard.pulse", 32'(a_ill), 32'd0);
    drive(1, 6'h3f, 0, 1);
    chk("ill_flush.pulse", 32'(a_ill), 32'd0);

    // Async reset in MUL cycle 2
    drive(1, 6'b000010, 0, 0);
    drive(0, 6'b000000, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    cycle();
    rst = 1'b0;
    drive(1, 6'b101010, 0, 0);
    drive(1, 6'b101000, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 18)] : 6'($urandom);
      if ($urandom_range(0, 4) == 0) op = 6'b000010;
      drive(($urandom_range(0, 9) != 0), op, ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 11) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
